// File: rtl/mdiv_fault_checker.sv
// Multiply/divide result checker: recomputes A*B (or |Q|*|B| + R) with a 16-step
// shift-add and reports a fault verdict, syndrome and saturating fault count.
module mdiv_fault_checker (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_op,
  input  logic [31:0] in_a,
  input  logic [15:0] in_b,
  input  logic [31:0] in_result,
  input  logic [31:0] in_remainder,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_fault,
  output logic        out_rem_err,
  output logic        out_divzero,
  output logic [31:0] out_syndrome,
  output logic        out_op,
  output logic [15:0] fault_count
);

  typedef enum logic [2:0] {IDLE, PREP, ITER, CMP, DONE} state_t;

  state_t state, state_nxt;

  logic        op_q;
  logic [31:0] a_q;
  logic [15:0] b_q;
  logic [31:0] result_q;
  logic [31:0] rem_q;
  logic [31:0] abs_a;
  logic [15:0] abs_b;
  logic        sign_q;
  logic [31:0] mcand;
  logic [47:0] acc;
  logic [3:0]  cnt;

  logic [31:0] abs_a_c;
  logic [15:0] abs_b_c;
  logic        sign_c;
  logic [31:0] q_mag_c;

  logic [31:0] mul_expected;
  logic [47:0] recomputed;
  logic        cmp_fault;
  logic        cmp_rem_err;
  logic        cmp_divzero;
  logic [31:0] cmp_syndrome;

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = PREP;
      end
      PREP: state_nxt = ITER;
      ITER: if (cnt == 4'd15) state_nxt = CMP;
      CMP:  state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Magnitudes; negating -2^31 naturally yields 0x80000000 as an unsigned value.
  always_comb begin
    abs_a_c = a_q[31] ? (~a_q + 32'd1) : a_q;
    abs_b_c = b_q[15] ? (~b_q + 16'd1) : b_q;
    sign_c  = a_q[31] ^ b_q[15];
    q_mag_c = sign_c ? (~result_q + 32'd1) : result_q;
  end

  always_comb begin
    mul_expected = sign_q ? (~acc[31:0] + 32'd1) : acc[31:0];
    recomputed   = acc + {16'b0, rem_q};
    cmp_fault    = 1'b0;
    cmp_rem_err  = 1'b0;
    cmp_divzero  = 1'b0;
    cmp_syndrome = 32'd0;
    if (!op_q) begin
      cmp_syndrome = mul_expected ^ result_q;
      cmp_fault    = (cmp_syndrome != 32'd0);
    end else if (abs_b == 16'd0) begin
      cmp_divzero = 1'b1;
    end else begin
      cmp_syndrome = recomputed[31:0] ^ abs_a;
      cmp_rem_err  = (rem_q >= {16'b0, abs_b});
      cmp_fault    = (recomputed != {16'b0, abs_a}) || cmp_rem_err;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      op_q         <= 1'b0;
      a_q          <= 32'd0;
      b_q          <= 16'd0;
      result_q     <= 32'd0;
      rem_q        <= 32'd0;
      abs_a        <= 32'd0;
      abs_b        <= 16'd0;
      sign_q       <= 1'b0;
      mcand        <= 32'd0;
      acc          <= 48'd0;
      cnt          <= 4'd0;
      out_fault    <= 1'b0;
      out_rem_err  <= 1'b0;
      out_divzero  <= 1'b0;
      out_syndrome <= 32'd0;
      out_op       <= 1'b0;
      fault_count  <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q     <= in_op;
            a_q      <= in_a;
            b_q      <= in_b;
            result_q <= in_result;
            rem_q    <= in_remainder;
          end
        end
        PREP: begin
          abs_a  <= abs_a_c;
          abs_b  <= abs_b_c;
          sign_q <= sign_c;
          mcand  <= op_q ? q_mag_c : abs_a_c;
          acc    <= 48'd0;
          cnt    <= 4'd0;
        end
        ITER: begin
          if (abs_b[cnt]) acc <= acc + ({16'b0, mcand} << cnt);
          cnt <= cnt + 4'd1;
        end
        CMP: begin
          out_fault    <= cmp_fault;
          out_rem_err  <= cmp_rem_err;
          out_divzero  <= cmp_divzero;
          out_syndrome <= cmp_syndrome;
          out_op       <= op_q;
          if (cmp_fault && fault_count != 16'hFFFF) fault_count <= fault_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdiv_fault_checker.sv
// Bench for mdiv_fault_checker: directed cases plus random traffic checked against
// an arithmetic reference model built on 64-bit integer products.
module tb_mdiv_fault_checker;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_op;
  logic [31:0] in_a;
  logic [15:0] in_b;
  logic [31:0] in_result;
  logic [31:0] in_remainder;
  logic        out_valid;
  logic        out_ready;
  logic        out_fault;
  logic        out_rem_err;
  logic        out_divzero;
  logic [31:0] out_syndrome;
  logic        out_op;
  logic [15:0] fault_count;

  int pass_count = 0;
  int check_count = 0;
  logic [15:0] exp_fc = 16'd0;

  always #5 clock = ~clock;

  mdiv_fault_checker dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_result(in_result), .in_remainder(in_remainder),
    .out_valid(out_valid), .out_ready(out_ready), .out_fault(out_fault),
    .out_rem_err(out_rem_err), .out_divzero(out_divzero), .out_syndrome(out_syndrome),
    .out_op(out_op), .fault_count(fault_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
  endtask

  // Reference verdict straight from signed integer arithmetic.
  task automatic model(input logic op, input logic [31:0] a, input logic [15:0] b,
                       input logic [31:0] res, input logic [31:0] rem,
                       output logic fault, output logic rem_err, output logic divzero,
                       output logic [31:0] syn);
    longint sa, sb, prod;
    longint unsigned mag_a, mag_b, recomp;
    logic [31:0] qm;
    logic [31:0] expv;
    logic sign;
    sa = $signed(a);
    sb = $signed(b);
    mag_a = (sa < 0) ? -sa : sa;
    mag_b = (sb < 0) ? -sb : sb;
    sign = (sa < 0) ^ (sb < 0);
    fault = 1'b0; rem_err = 1'b0; divzero = 1'b0; syn = 32'd0;
    if (!op) begin
      prod = sa * sb;
      expv = prod[31:0];
      syn = expv ^ res;
      fault = (syn != 32'd0);
    end else if (sb == 0) begin
      divzero = 1'b1;
    end else begin
      qm = sign ? (32'd0 - res) : res;
      recomp = longint'({32'd0, qm}) * mag_b + longint'({32'd0, rem});
      rem_err = ({32'd0, rem} >= mag_b);
      syn = recomp[31:0] ^ mag_a[31:0];
      fault = (recomp != mag_a) || rem_err;
    end
  endtask

  task automatic applyStimulus(input logic op, input logic [31:0] a, input logic [15:0] b,
                               input logic [31:0] res, input logic [31:0] rem);
    int waited;
    waited = 0;
    @(negedge clock);
    while (!in_ready && waited < 40) begin
      @(negedge clock);
      waited++;
    end
    checkOutput("in_ready_before_req", {31'd0, in_ready}, 32'd1);
    in_op = op; in_a = a; in_b = b; in_result = res; in_remainder = rem;
    in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    in_a = $urandom;
    in_result = $urandom;
  endtask

  task automatic run_txn(input logic op, input logic [31:0] a, input logic [15:0] b,
                         input logic [31:0] res, input logic [31:0] rem, input int stall);
    logic ef, er, ed;
    logic [31:0] es;
    int lat;
    model(op, a, b, res, rem, ef, er, ed, es);
    if (ef && exp_fc != 16'hFFFF) exp_fc = exp_fc + 16'd1;
    applyStimulus(op, a, b, res, rem);
    lat = 0;
    while (lat < 40) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      if (out_valid) break;
    end
    checkOutput("latency", lat, 18);
    for (int s = 0; s <= stall; s++) begin
      if (s > 0) begin
        @(posedge clock);
        @(negedge clock);
      end
      checkOutput("out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("in_ready_busy", {31'd0, in_ready}, 32'd0);
      checkOutput("out_fault", {31'd0, out_fault}, {31'd0, ef});
      checkOutput("out_rem_err", {31'd0, out_rem_err}, {31'd0, er});
      checkOutput("out_divzero", {31'd0, out_divzero}, {31'd0, ed});
      checkOutput("out_syndrome", out_syndrome, es);
      checkOutput("out_op", {31'd0, out_op}, {31'd0, op});
      checkOutput("fault_count", {16'd0, fault_count}, {16'd0, exp_fc});
    end
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;
    checkOutput("out_valid_after_take", {31'd0, out_valid}, 32'd0);
    checkOutput("in_ready_after_take", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic        rop;
    logic [31:0] ra, rres, rrem;
    logic [15:0] rb;
    longint      sa, sb, q, p;
    int          vo_seen;

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_op = 1'b0;
    in_a = 32'd0; in_b = 16'd0; in_result = 32'd0; in_remainder = 32'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_fault_count", {16'd0, fault_count}, 32'd0);
    checkOutput("rst_syndrome", out_syndrome, 32'd0);
    checkOutput("rst_fault", {31'd0, out_fault}, 32'd0);
    reset_n = 1'b1;

    $display("[TB] directed cases");
    run_txn(1'b0, 32'd1000, 16'hFFFD, 32'hFFFFF448, 32'd0, 0);
    run_txn(1'b0, 32'd1000, 16'hFFFD, 32'hFFFFF4C8, 32'd0, 0);
    checkOutput("fc_after_flip", {16'd0, fault_count}, 32'd1);
    run_txn(1'b1, 32'hFFFFFF9C, 16'd7, 32'hFFFFFFF2, 32'd2, 0);
    run_txn(1'b1, 32'hFFFFFF9C, 16'd7, 32'hFFFFFFF6, 32'd2, 0);
    run_txn(1'b1, 32'd50, 16'd7, 32'd7, 32'd1, 0);
    run_txn(1'b1, 32'd50, 16'd7, 32'd6, 32'd8, 0);
    run_txn(1'b1, 32'h12345678, 16'd0, 32'hDEADBEEF, 32'd3, 5);
    run_txn(1'b0, 32'h80000000, 16'h8000, 32'd0, 32'd0, 1);

    $display("[TB] reset during ITER");
    applyStimulus(1'b0, 32'd1000, 16'hFFFD, 32'hFFFFF4C8, 32'd0);
    repeat (5) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    out_ready = 1'b0;
    exp_fc = 16'd0;
    checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("midrst_fault_count", {16'd0, fault_count}, 32'd0);
    vo_seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clock);
      if (out_valid) vo_seen++;
    end
    checkOutput("midrst_no_verdict", vo_seen, 0);
    run_txn(1'b1, 32'hFFFFFF9C, 16'd7, 32'hFFFFFFF2, 32'd2, 0);

    $display("[TB] random traffic");
    for (int n = 0; n < 40; n++) begin
      rop = $urandom_range(0, 1);
      ra = $urandom;
      if (n % 5 == 0) ra = ra >> $urandom_range(1, 28);
      rb = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      sa = $signed(ra);
      sb = $signed(rb);
      rrem = 32'd0;
      if (!rop) begin
        p = sa * sb;
        rres = p[31:0];
      end else if (sb != 0) begin
        q = sa / sb;
        rres = q[31:0];
        p = sa - q * sb;
        if (p < 0) p = -p;
        rrem = p[31:0];
        if ($urandom_range(0, 3) == 0) rrem = rrem + ((sb < 0) ? 32'(-sb) : 32'(sb));
      end else begin
        rres = $urandom;
      end
      if ($urandom_range(0, 2) == 0) rres = rres ^ (32'd1 << $urandom_range(0, 31));
      run_txn(rop, ra, rb, rres, rrem, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/mdiv_fault_checker.md
MDIV_FAULT_CHECKER -- requirements
Module: mdiv_fault_checker

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
- clock  in  1  sole clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- in_valid  in  1  request present
- in_ready  out  1  checker can accept a request
- in_op  in  1  0 = check multiply, 1 = check divide
- in_a  in  32  signed operand A (multiplicand/dividend)
- in_b  in  16  signed operand B (multiplier/divisor)
- in_result  in  32  product or quotient under test
- in_remainder  in  32  unsigned magnitude remainder under test (divide only)
- out_valid  out  1  check verdict present
- out_ready  in  1  consumer takes verdict
- out_fault  out  1  result inconsistent with operands
- out_rem_err  out  1  divide: in_remainder >= |in_b|
- out_divzero  out  1  divide with in_b = 0
- out_syndrome  out  32  recomputed value XOR reference value
- out_op  out  1  op of the reported check
- fault_count  out  16  saturating count of reported faults
REQ-002 SHALL have no parameters; all widths fixed as above.

Function
REQ-003 SHALL accept a request on a rising edge with in_valid=1 and in_ready=1, registering all in_* fields.
REQ-004 SHALL drive in_ready=1 only in state IDLE.
REQ-005 SHALL implement states IDLE -> PREP -> ITER -> CMP -> DONE -> IDLE.
REQ-006 PREP (1 cycle) SHALL form |A| (32-bit unsigned; 0x80000000 for -2^31), |B| (16-bit unsigned), sign = A[31]^B[15]; for divide, |Q| = magnitude of in_result (two's-complement negate if sign=1).
REQ-007 ITER SHALL last exactly 16 cycles, one bit of |B| per cycle, LSB first, shift-add into a 48-bit accumulator: multiplicand is |A| (multiply) or |Q| (divide).
REQ-008 CMP (1 cycle), multiply: expected = low 32 bits of product, negated if sign=1; out_syndrome = expected XOR in_result; out_fault = (out_syndrome != 0).
REQ-009 CMP, divide with |B| != 0: recomputed = accumulator + zero-extended in_remainder (48-bit); out_syndrome = recomputed[31:0] XOR |A|; out_rem_err = (in_remainder >= |B|); out_fault = (recomputed != {16'b0,|A|}) OR out_rem_err.
REQ-010 Divide with in_b = 0: out_divzero=1, out_fault=0, out_rem_err=0, out_syndrome=0; latency unchanged.
REQ-011 out_valid SHALL rise on the 18th rising edge after the accepting edge; DONE SHALL hold all out_* stable until out_valid=1 and out_ready=1 on an edge, then go to IDLE.
REQ-012 fault_count SHALL increment by 1 on the edge entering DONE when out_fault=1, saturating at 0xFFFF.
REQ-013 out_fault, out_rem_err, out_divzero, out_syndrome, out_op SHALL be meaningful only while out_valid=1.
REQ-014 No new request SHALL be accepted in the cycle out_valid is consumed; in_ready rises the following cycle (IDLE).

Reset
REQ-015 reset_n=0 at a rising edge SHALL force IDLE, in_ready=1 after that edge, out_valid=0, out_fault=0, out_rem_err=0, out_divzero=0, out_syndrome=0, out_op=0, fault_count=0, accumulator and counters 0.
REQ-016 Reset mid-operation (any state) SHALL discard the in-flight check with no verdict and no fault_count change other than clearing.
REQ-017 Reset SHALL override simultaneous in_valid/out_ready handshakes.

Verification
REQ-018 Multiply A=1000, B=-3, result=0xFFFFF448 -> 18 edges later out_valid=1, out_fault=0, out_syndrome=0, fault_count=0.
REQ-019 Same, result=0xFFFFF4C8 (bit 7 flipped) -> out_fault=1, out_syndrome=0x00000080, fault_count=1.
REQ-020 Divide A=-100, B=7, result=0xFFFFFFF2, remainder=2 -> out_fault=0, out_rem_err=0; result=0xFFFFFFF6 (bit 2 flipped) -> out_fault=1, out_syndrome=0x0000002C.
REQ-021 Divide A=50, B=7, result=7, remainder=1 -> out_fault=0; remainder=8, result=6 -> out_rem_err=1, out_fault=1, out_syndrome=0.
REQ-022 Divide B=0, any A/result -> out_divzero=1, out_fault=0, fault_count unchanged; out_ready held 0 for 5 cycles -> outputs stable, in_ready=0 throughout.
REQ-023 reset_n=0 on the 5th ITER cycle -> out_valid never asserts, in_ready=1 after the reset edge, fault_count=0; next request checks correctly.
